// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate arbiter and its timer.
package parking_pkg;

  // Gate ownership FSM states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPEN_IN  = 3'd1,
    PASS_IN  = 3'd2,
    OPEN_OUT = 3'd3,
    PASS_OUT = 3'd4
  } gate_state_t;

  localparam int DEFAULT_CAPACITY = 15;
  localparam int DEFAULT_TIMEOUT  = 100;
  localparam int TIMER_W          = 8;

  // True for the states in which the barrier is raised.
  function automatic logic is_open_state(input gate_state_t s);
    return (s == OPEN_IN) || (s == PASS_IN) || (s == OPEN_OUT) || (s == PASS_OUT);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Approach down-counter: loaded when a grant is issued, counts the cycles
// the granted car spends reaching the gate lane.
module gate_timer
  import parking_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(TIMEOUT);

  logic [TIMER_W-1:0] value;

  // Load on grant, decrement while waiting, hold at zero otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= LOAD_VAL;
    end else if (enable && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  // Expired in the waiting cycle whose decrement reaches zero, so the
  // granted side gets exactly TIMEOUT cycles in OPEN before abandonment.
  assign expired = enable && (value == TIMER_W'(1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared entry/exit gate arbiter. One side owns the gate at a time; ties in
// IDLE are broken round-robin. Occupancy pulses go to an external counter.
//
// Handshake: entry_req/exit_req are level requests sampled only in IDLE;
// a grant is the registered grant_entry/grant_exit level, held until the car
// clears the lane (pass_sensor high then low) or the approach timer expires.
// inc/dec/timeout_err are one-cycle registered pulses in the first IDLE cycle.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEFAULT_CAPACITY,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        entry_req,
  input  logic        exit_req,
  input  logic        pass_sensor,
  input  logic [3:0]  count,
  output logic        gate_open,
  output logic        grant_entry,
  output logic        grant_exit,
  output logic        inc,
  output logic        dec,
  output logic        full,
  output logic        timeout_err,
  output gate_state_t state
);

  localparam logic [3:0] CAP4 = 4'(CAPACITY);

  logic entry_ok;
  logic exit_ok;
  logic pick_entry;
  logic pick_exit;
  logic last_served_exit;
  logic timer_load;
  logic timer_enable;
  logic timer_expired;

  assign full = (count >= CAP4);

  // Eligibility and round-robin choice; only consulted while IDLE.
  always_comb begin
    entry_ok   = entry_req && !full;
    exit_ok    = exit_req && (count != 4'd0);
    pick_entry = entry_ok && (!exit_ok || last_served_exit);
    pick_exit  = exit_ok && (!entry_ok || !last_served_exit);
  end

  // Timer loads with the grant and runs only while the car has not arrived.
  always_comb begin
    timer_load   = (state == IDLE) && (pick_entry || pick_exit);
    timer_enable = ((state == OPEN_IN) || (state == OPEN_OUT)) && !pass_sensor;
  end

  gate_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gate_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Gate ownership FSM with registered barrier, grant and pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      gate_open        <= 1'b0;
      grant_entry      <= 1'b0;
      grant_exit       <= 1'b0;
      inc              <= 1'b0;
      dec              <= 1'b0;
      timeout_err      <= 1'b0;
      last_served_exit <= 1'b1;
    end else begin
      inc         <= 1'b0;
      dec         <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_entry) begin
            state            <= OPEN_IN;
            gate_open        <= 1'b1;
            grant_entry      <= 1'b1;
            grant_exit       <= 1'b0;
            last_served_exit <= 1'b0;
          end else if (pick_exit) begin
            state            <= OPEN_OUT;
            gate_open        <= 1'b1;
            grant_entry      <= 1'b0;
            grant_exit       <= 1'b1;
            last_served_exit <= 1'b1;
          end
        end
        OPEN_IN: begin
          if (pass_sensor) begin
            state <= PASS_IN;
          end else if (timer_expired) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            grant_entry <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        PASS_IN: begin
          if (!pass_sensor) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            grant_entry <= 1'b0;
            inc         <= 1'b1;
          end
        end
        OPEN_OUT: begin
          if (pass_sensor) begin
            state <= PASS_OUT;
          end else if (timer_expired) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            grant_exit  <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        PASS_OUT: begin
          if (!pass_sensor) begin
            state      <= IDLE;
            gate_open  <= 1'b0;
            grant_exit <= 1'b0;
            dec        <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          gate_open   <= 1'b0;
          grant_entry <= 1'b0;
          grant_exit  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: vector table plus timeout sequences.
module tb_parking_gate_arbiter;
  import parking_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        entry_req = 1'b0;
  logic        exit_req = 1'b0;
  logic        pass_sensor = 1'b0;
  logic [3:0]  count = 4'd0;
  logic        gate_open, grant_entry, grant_exit, inc, dec, full, timeout_err;
  gate_state_t state;

  int tests = 0;
  int failed = 0;

  parking_gate_arbiter #(.CAPACITY(15), .TIMEOUT(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .pass_sensor (pass_sensor),
    .count       (count),
    .gate_open   (gate_open),
    .grant_entry (grant_entry),
    .grant_exit  (grant_exit),
    .inc         (inc),
    .dec         (dec),
    .full        (full),
    .timeout_err (timeout_err),
    .state       (state)
  );

  // Clock
  always #5 clk = ~clk;

  // Output bits: gate_open, grant_entry, grant_exit, inc, dec, full, timeout_err
  function automatic logic [6:0] obs();
    return {gate_open, grant_entry, grant_exit, inc, dec, full, timeout_err};
  endfunction

  typedef struct {
    logic        r, e, x, p;
    logic [3:0]  c;
    logic [6:0]  exp;
    gate_state_t st;
  } vec_t;

  localparam int NV = 30;
  vec_t v[NV];

  // Driver: apply inputs at negedge, then sample 1 time unit after posedge.
  task automatic step(input logic r, input logic e, input logic x,
                      input logic p, input logic [3:0] c);
    @(negedge clk);
    reset = r; entry_req = e; exit_req = x; pass_sensor = p; count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bits(input string name, input logic [6:0] exp);
    tests++;
    if (obs() !== exp) begin
      failed++;
      $display("FAIL %s: outputs %b, required %b (gate,ge,gx,inc,dec,full,terr)",
               name, obs(), exp);
    end
  endtask

  task automatic check_state(input string name, input gate_state_t exp);
    tests++;
    if (state !== exp) begin
      failed++;
      $display("FAIL %s: state %0d, required %0d", name, state, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Continuous invariants, checked every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      tests++;
      if ((grant_entry && grant_exit) || (inc && dec) ||
          (gate_open !== (grant_entry || grant_exit))) begin
        failed++;
        $display("FAIL invariant: ge=%b gx=%b inc=%b dec=%b gate=%b",
                 grant_entry, grant_exit, inc, dec, gate_open);
      end
    end
  end

  initial begin
    int n;
    int te_seen;
    int inc_seen;

    // Reset and single entry, pass_sensor high for 4 cycles.
    v[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  7'b0000000, IDLE};
    v[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  7'b1100000, OPEN_IN};
    v[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  7'b1100000, PASS_IN};
    v[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  7'b1100000, PASS_IN};
    v[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  7'b1100000, PASS_IN};
    v[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  7'b1100000, PASS_IN};
    v[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  7'b0001000, IDLE};
    v[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  7'b0000000, IDLE};
    // Both requests from reset: entry first, then exit.
    v[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  7'b0000000, IDLE};
    v[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  7'b1100000, OPEN_IN};
    v[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  7'b1100000, PASS_IN};
    v[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  7'b0001000, IDLE};
    v[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  7'b1010000, OPEN_OUT};
    v[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd5,  7'b1010000, PASS_OUT};
    v[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd5,  7'b0000100, IDLE};
    v[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd5,  7'b0000000, IDLE};
    // Lot full: entry never granted.
    v[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 7'b0000010, IDLE};
    v[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 7'b0000010, IDLE};
    v[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 7'b0000010, IDLE};
    // Empty lot blocks exit; count change mid-grant does not abort.
    v[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  7'b0000000, IDLE};
    v[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2,  7'b1010000, OPEN_OUT};
    v[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  7'b1010000, PASS_OUT};
    v[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  7'b0000100, IDLE};
    v[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  7'b0000000, IDLE};
    // Reset while in PASS_IN: gate drops, no inc afterwards.
    v[24] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  7'b1100000, OPEN_IN};
    v[25] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  7'b1100000, PASS_IN};
    v[26] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  7'b0000000, IDLE};
    v[27] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  7'b0000000, IDLE};
    // Full lot still lets a car exit.
    v[28] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 7'b1010010, OPEN_OUT};
    v[29] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 7'b1010010, OPEN_OUT};

    for (int i = 0; i < NV; i++) begin
      step(v[i].r, v[i].e, v[i].x, v[i].p, v[i].c);
      check_bits($sformatf("vec%0d_out", i), v[i].exp);
      check_state($sformatf("vec%0d_state", i), v[i].st);
    end

    // Timeout on entry: exactly TIMEOUT cycles in OPEN_IN, then one error pulse.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    check_state("to_grant", OPEN_IN);
    n = 0; te_seen = 0; inc_seen = 0;
    while (state == OPEN_IN && n < 200) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
      n++;
      if (timeout_err) te_seen++;
      if (inc) inc_seen++;
    end
    check_int("to_open_cycles", n, 100);
    check_state("to_idle", IDLE);
    check_bits("to_pulse", 7'b0000001);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    check_bits("to_pulse_end", 7'b0000000);
    check_int("to_pulse_count", te_seen, 1);
    check_int("to_no_inc", inc_seen, 0);

    // Car arrives in the last waiting cycle on exit: no timeout, dec follows.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
    check_state("late_grant", OPEN_OUT);
    te_seen = 0;
    for (int k = 0; k < 99; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
      if (timeout_err || state != OPEN_OUT) te_seen++;
    end
    check_int("late_still_open", te_seen, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    check_state("late_pass", PASS_OUT);
    check_bits("late_pass_out", 7'b1010000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    check_state("late_hold", PASS_OUT);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
    check_bits("late_dec", 7'b0000100);
    check_state("late_idle", IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 15, meaning the maximum lot occupancy (1..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 100, meaning the cycles a granted car may take to reach the gate before the grant is abandoned (1..255).
REQ-003 Port: clk  input  1  single clock, all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: entry_req  input  1  car waiting at the entry side of the shared gate (level).
REQ-006 Port: exit_req  input  1  car waiting at the exit side of the shared gate (level).
REQ-007 Port: pass_sensor  input  1  high while a car occupies the gate lane.
REQ-008 Port: count  input  4  current occupancy from the lot counter.
REQ-009 Port: gate_open  output  1  barrier raise command.
REQ-010 Port: grant_entry / grant_exit  output  1 each  current owner of the gate.
REQ-011 Port: inc / dec  output  1 each  single-cycle pulses to the lot counter.
REQ-012 Port: full  output  1  high when count >= CAPACITY (combinational).
REQ-013 Port: timeout_err  output  1  single-cycle pulse when a grant is abandoned.

Function
REQ-014 The FSM SHALL have states IDLE, OPEN_IN, PASS_IN, OPEN_OUT and PASS_OUT.
REQ-015 Entry SHALL be eligible when entry_req=1 and full=0; exit SHALL be eligible when exit_req=1 and count!=0.
REQ-016 In IDLE with one eligible side, the FSM SHALL move next cycle to OPEN_IN (entry) or OPEN_OUT (exit).
REQ-017 With both eligible in IDLE, the side opposite to last_served SHALL win (round-robin); last_served updates on every grant.
REQ-018 gate_open SHALL be registered and high exactly while in OPEN_* or PASS_*; grant_entry high in OPEN_IN/PASS_IN, grant_exit high in OPEN_OUT/PASS_OUT; never both.
REQ-019 OPEN_x -> PASS_x SHALL occur on the first cycle pass_sensor=1.
REQ-020 PASS_x -> IDLE SHALL occur on the first cycle pass_sensor=0, with inc (PASS_IN) or dec (PASS_OUT) high for exactly that next cycle.
REQ-021 A timer SHALL load TIMEOUT on entering OPEN_x and decrement each OPEN_x cycle; on reaching 0 without pass_sensor, the FSM SHALL go to IDLE, pulse timeout_err one cycle, and issue no inc/dec.
REQ-022 PASS_x SHALL have no timeout; the gate SHALL stay open while pass_sensor=1.
REQ-023 Requests SHALL be ignored outside IDLE; IDLE SHALL last at least one cycle between grants.
REQ-024 count changes during a grant SHALL NOT abort it; eligibility is evaluated only in IDLE.
REQ-025 inc and dec SHALL never be high in the same cycle.

Reset
REQ-026 With reset=0 at a clock edge: state=IDLE, gate_open=0, grants=0, inc=dec=timeout_err=0, timer=0, last_served=exit (entry wins first tie).
REQ-027 Reset mid-grant SHALL close the gate immediately at that edge and suppress any pending inc/dec.

Structure
REQ-028 Package parking_pkg SHALL hold the state enum typedef and default CAPACITY/TIMEOUT constants.
REQ-029 The timeout down-counter SHALL be a sub-module named gate_timer (load, enable, expired).

Verification
REQ-030 Entry_req=1, count=3, pass_sensor high 4 cycles then low -> gate_open 1 from cycle after request until IDLE; one inc pulse; no dec.
REQ-031 Both requests from reset, count=5 -> entry granted first; after completion exit granted; inc then dec.
REQ-032 Entry_req=1, count=15 (CAPACITY 15), exit_req=0 -> no grant, full=1, gate_open=0 forever.
REQ-033 Exit_req=1, count=0 -> no grant; then count=2 -> OPEN_OUT next cycle.
REQ-034 Grant entry, pass_sensor held 0 for TIMEOUT=100 cycles -> IDLE, timeout_err single pulse, no inc.
REQ-035 Reset asserted in PASS_IN -> gate_open=0 next edge, no inc, state IDLE.
